// File: rtl/sound_event_arbiter_pkg.sv
// rtl/sound_event_arbiter_pkg.sv - shared state, tone and source encodings for the sound event arbiter
package sound_event_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_GAP  = 2'd2
  } arb_state_e;

  localparam logic [2:0] SND_SILENT = 3'd0;
  localparam logic [2:0] SND_MOVE   = 3'd1;
  localparam logic [2:0] SND_LEVEL  = 3'd2;
  localparam logic [2:0] SND_DEAD   = 3'd3;
  localparam logic [2:0] SND_WIN    = 3'd4;

  localparam int SRC_MOVE  = 0;
  localparam int SRC_LEVEL = 1;
  localparam int SRC_DEAD  = 2;
  localparam int SRC_WIN   = 3;

  // Source i always plays tone code i+1; code 0 is reserved for silence.
  function automatic logic [2:0] tone_code(input int src);
    return 3'(src + 1);
  endfunction

endpackage

// File: rtl/sound_event_arbiter_pri_enc_hi.sv
// rtl/sound_event_arbiter_pri_enc_hi.sv - highest set bit strictly above an optional floor index
module pri_enc_hi #(
  parameter int N_SRC = 4,
  parameter int IDX_W = 2
) (
  input  logic [N_SRC-1:0] vec_i,
  input  logic             use_floor_i,
  input  logic [IDX_W-1:0] floor_i,
  output logic             valid_o,
  output logic [IDX_W-1:0] idx_o
);

  always_comb begin
    valid_o = 1'b0;
    idx_o   = '0;
    // Ascending scan: the last qualifying bit is the highest one.
    for (int i = 0; i < N_SRC; i++) begin
      if (vec_i[i] && (!use_floor_i || (i > int'(floor_i)))) begin
        valid_o = 1'b1;
        idx_o   = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/sound_event_arbiter.sv
// rtl/sound_event_arbiter.sv - latches game sound events and plays the highest-priority one
// as a fixed-length tone followed by a silence gap.
module sound_event_arbiter
  import sound_event_arbiter_pkg::*;
#(
  parameter int N_SRC    = 4,
  parameter int TONE_CYC = 25000000,
  parameter int GAP_CYC  = 2500000,
  parameter int PREEMPT  = 1,
  parameter int CNT_W    = 25,
  localparam int IDX_W   = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [N_SRC-1:0] req,
  output logic [2:0]       sel,
  output logic             busy,
  output logic [IDX_W-1:0] cur_src,
  output logic             dropped
);

  localparam logic [CNT_W-1:0] TONE_LOAD = CNT_W'(TONE_CYC - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(GAP_CYC - 1);

  arb_state_e       state_q;
  logic [N_SRC-1:0] pending_q, pending_d, clr;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       sel_q;
  logic             busy_q, dropped_q;
  logic [IDX_W-1:0] cur_src_q;

  logic             idle_vld, pre_vld, take_pre;
  logic [IDX_W-1:0] idle_idx, pre_idx;

  pri_enc_hi #(.N_SRC(N_SRC), .IDX_W(IDX_W)) u_enc_idle (
    .vec_i      (pending_q),
    .use_floor_i(1'b0),
    .floor_i    ('0),
    .valid_o    (idle_vld),
    .idx_o      (idle_idx)
  );

  pri_enc_hi #(.N_SRC(N_SRC), .IDX_W(IDX_W)) u_enc_pre (
    .vec_i      (pending_q),
    .use_floor_i(1'b1),
    .floor_i    (cur_src_q),
    .valid_o    (pre_vld),
    .idx_o      (pre_idx)
  );

  assign take_pre = (PREEMPT != 0) && (state_q == ST_PLAY) && pre_vld;

  // A fresh request on the same cycle as its clear re-arms the bit.
  always_comb begin
    clr = '0;
    if (state_q == ST_IDLE && idle_vld) clr[idle_idx] = 1'b1;
    if (take_pre)                       clr[pre_idx]  = 1'b1;
    pending_d = en ? ((pending_q & ~clr) | req) : '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      pending_q <= '0;
      cnt_q     <= '0;
      sel_q     <= SND_SILENT;
      busy_q    <= 1'b0;
      cur_src_q <= '0;
      dropped_q <= 1'b0;
    end else begin
      pending_q <= pending_d;
      dropped_q <= 1'b0;
      if (!en) begin
        state_q <= ST_IDLE;
        sel_q   <= SND_SILENT;
        busy_q  <= 1'b0;
        cnt_q   <= '0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (idle_vld) begin
              state_q   <= ST_PLAY;
              sel_q     <= tone_code(int'(idle_idx));
              cur_src_q <= idle_idx;
              cnt_q     <= TONE_LOAD;
              busy_q    <= 1'b1;
            end
          end
          ST_PLAY: begin
            if (take_pre) begin
              sel_q     <= tone_code(int'(pre_idx));
              cur_src_q <= pre_idx;
              cnt_q     <= TONE_LOAD;
              dropped_q <= 1'b1;
            end else if (cnt_q == '0) begin
              state_q <= ST_GAP;
              sel_q   <= SND_SILENT;
              cnt_q   <= GAP_LOAD;
            end else begin
              cnt_q <= cnt_q - 1'b1;
            end
          end
          ST_GAP: begin
            if (cnt_q == '0) begin
              state_q <= ST_IDLE;
              busy_q  <= 1'b0;
            end else begin
              cnt_q <= cnt_q - 1'b1;
            end
          end
          default: begin
            state_q <= ST_IDLE;
            sel_q   <= SND_SILENT;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign sel     = sel_q;
  assign busy    = busy_q;
  assign cur_src = cur_src_q;
  assign dropped = dropped_q;

endmodule

// File: tb/tb_sound_event_arbiter.sv
// tb/tb_sound_event_arbiter.sv - directed scoreboard bench for sound_event_arbiter
module tb_sound_event_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en  = 1'b1;
  logic [3:0] req = 4'b0000;
  logic [2:0] sel;
  logic       busy;
  logic [1:0] cur_src;
  logic       dropped;

  typedef struct packed {
    logic [2:0] sel;
    logic       busy;
    logic       bcare;
    logic       drop;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc_n = 0;

  sound_event_arbiter #(
    .N_SRC(4), .TONE_CYC(8), .GAP_CYC(2), .PREEMPT(1), .CNT_W(4)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .req(req),
    .sel(sel), .busy(busy), .cur_src(cur_src), .dropped(dropped)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s cyc=%0d got=%0d exp=%0d", tag, cyc_n, got, exp);
    end
  endtask

  task automatic push(input logic [2:0] s, input logic b, input logic bc, input logic d, input int n);
    exp_t e;
    e.sel = s; e.busy = b; e.bcare = bc; e.drop = d;
    repeat (n) sb.push_back(e);
  endtask

  // One clock cycle: drive inputs, sample mid-cycle against the scoreboard head.
  task automatic cyc(input logic [3:0] r, input logic e);
    exp_t x;
    req = r;
    en  = e;
    @(negedge clk);
    if (sb.size() > 0) begin
      x = sb.pop_front();
      chk("sel", 32'(sel), 32'(x.sel));
      chk("dropped", 32'(dropped), 32'(x.drop));
      if (x.bcare) chk("busy", 32'(busy), 32'(x.busy));
    end
    @(posedge clk);
    #1;
    req = 4'b0000;
    en  = 1'b1;
    cyc_n++;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(4'b0000, 1'b1);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_sel", 32'(sel), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_cur_src", 32'(cur_src), 32'd0);
    chk("rst_dropped", 32'(dropped), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Single move event: 2-cycle latency, 8-cycle tone, gap, idle.
    push(3'd0, 1'b0, 1'b1, 1'b0, 2);
    push(3'd1, 1'b1, 1'b1, 1'b0, 8);
    push(3'd0, 1'b1, 1'b1, 1'b0, 2);
    push(3'd0, 1'b0, 1'b0, 1'b0, 1);
    push(3'd0, 1'b0, 1'b1, 1'b0, 1);
    cyc(4'b0001, 1'b1);
    idle(13);
    chk("t1_cur_src", 32'(cur_src), 32'd0);

    // Simultaneous requests are served highest index first.
    push(3'd0, 1'b0, 1'b1, 1'b0, 2);
    push(3'd3, 1'b1, 1'b1, 1'b0, 8);
    push(3'd0, 1'b1, 1'b1, 1'b0, 2);
    push(3'd0, 1'b0, 1'b0, 1'b0, 1);
    push(3'd1, 1'b1, 1'b1, 1'b0, 8);
    push(3'd0, 1'b1, 1'b1, 1'b0, 2);
    push(3'd0, 1'b0, 1'b0, 1'b0, 1);
    push(3'd0, 1'b0, 1'b1, 1'b0, 2);
    cyc(4'b0101, 1'b1);
    idle(25);

    // Game win preempts move three cycles into the tone; move is not replayed.
    push(3'd0, 1'b0, 1'b1, 1'b0, 2);
    push(3'd1, 1'b1, 1'b1, 1'b0, 5);
    push(3'd4, 1'b1, 1'b1, 1'b1, 1);
    push(3'd4, 1'b1, 1'b1, 1'b0, 7);
    push(3'd0, 1'b1, 1'b1, 1'b0, 2);
    push(3'd0, 1'b0, 1'b0, 1'b0, 1);
    push(3'd0, 1'b0, 1'b1, 1'b0, 3);
    cyc(4'b0001, 1'b1);
    idle(4);
    cyc(4'b1000, 1'b1);
    idle(15);
    chk("t3_cur_src", 32'(cur_src), 32'd3);

    // Lower-priority request mid-tone waits for the gap.
    push(3'd0, 1'b0, 1'b1, 1'b0, 2);
    push(3'd3, 1'b1, 1'b1, 1'b0, 8);
    push(3'd0, 1'b1, 1'b1, 1'b0, 2);
    push(3'd0, 1'b0, 1'b0, 1'b0, 1);
    push(3'd2, 1'b1, 1'b1, 1'b0, 8);
    push(3'd0, 1'b1, 1'b1, 1'b0, 2);
    push(3'd0, 1'b0, 1'b0, 1'b0, 1);
    push(3'd0, 1'b0, 1'b1, 1'b0, 2);
    cyc(4'b0100, 1'b1);
    idle(3);
    cyc(4'b0010, 1'b1);
    idle(21);
    chk("t4_cur_src", 32'(cur_src), 32'd1);

    // en low for one cycle flushes the tone and ignores requests seen meanwhile.
    push(3'd0, 1'b0, 1'b1, 1'b0, 2);
    push(3'd3, 1'b1, 1'b1, 1'b0, 3);
    push(3'd0, 1'b0, 1'b1, 1'b0, 15);
    cyc(4'b0100, 1'b1);
    idle(3);
    cyc(4'b1111, 1'b0);
    idle(15);
    chk("t5_cur_src_held", 32'(cur_src), 32'd2);

    // Asynchronous reset in the middle of a tone.
    push(3'd0, 1'b0, 1'b1, 1'b0, 2);
    push(3'd2, 1'b1, 1'b1, 1'b0, 2);
    cyc(4'b0010, 1'b1);
    idle(3);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_sel", 32'(sel), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_cur_src", 32'(cur_src), 32'd0);
    chk("arst_dropped", 32'(dropped), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    push(3'd0, 1'b0, 1'b1, 1'b0, 2);
    push(3'd2, 1'b1, 1'b1, 1'b0, 8);
    push(3'd0, 1'b1, 1'b1, 1'b0, 2);
    push(3'd0, 1'b0, 1'b0, 1'b0, 1);
    push(3'd0, 1'b0, 1'b1, 1'b0, 1);
    cyc(4'b0010, 1'b1);
    idle(13);
    chk("t6_cur_src", 32'(cur_src), 32'd1);

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
